// File: rtl/rv32i_program_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
// The master side is the host bridge; the slave side is the loader itself.
interface rv32i_program_loader_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv32i_program_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them to
// instruction memory in order, and holds the core in reset until the image is complete.
module rv32i_program_loader #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len_words,
    rv32i_program_loader_if.slave bus,
    output logic                  core_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_W = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Saturate the requested length to the memory capacity.
    function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] len);
        return (len > DEPTH) ? DEPTH : len;
    endfunction

    state_t                state, state_n;
    logic [ADDR_WIDTH:0]   len_q, len_n;
    logic [ADDR_WIDTH:0]   word_q, word_n;
    logic [1:0]            lane_q, lane_n;
    logic [23:0]           asm_q, asm_n;
    logic                  we_q, we_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [31:0]           wdata_q, wdata_n;
    logic                  crn_n, busy_n, done_n, ovf_n;
    logic                  accept;

    assign bus.in_ready  = (state == LOAD);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign accept        = bus.in_valid && (state == LOAD);

    always_comb begin
        state_n = state;
        len_n   = len_q;
        word_n  = word_q;
        lane_n  = lane_q;
        asm_n   = asm_q;
        we_n    = 1'b0;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        ovf_n   = overflow;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    len_n   = clamp_len(len_words);
                    ovf_n   = (len_words > DEPTH);
                    word_n  = '0;
                    lane_n  = '0;
                    asm_n   = '0;
                    state_n = (len_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    lane_n = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: asm_n[7:0]   = bus.in_data;
                        2'd1: asm_n[15:8]  = bus.in_data;
                        2'd2: asm_n[23:16] = bus.in_data;
                        2'd3: begin
                            // Lane 3 goes straight to the write register so the
                            // assembly register is free for the next word's first byte.
                            we_n    = 1'b1;
                            addr_n  = word_q[ADDR_WIDTH-1:0];
                            wdata_n = {bus.in_data, asm_q};
                            word_n  = word_q + ONE_W;
                            if (word_n == len_q)
                                state_n = FLUSH;
                        end
                    endcase
                end
            end
            FLUSH: state_n = DONE;
            default: state_n = IDLE;
        endcase

        crn_n  = (state_n == DONE);
        done_n = (state_n == DONE);
        busy_n = (state_n == LOAD) || (state_n == FLUSH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            len_q        <= '0;
            word_q       <= '0;
            lane_q       <= '0;
            asm_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_n <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_n;
            len_q        <= len_n;
            word_q       <= word_n;
            lane_q       <= lane_n;
            asm_q        <= asm_n;
            we_q         <= we_n;
            addr_q       <= addr_n;
            wdata_q      <= wdata_n;
            core_reset_n <= crn_n;
            busy         <= busy_n;
            done         <= done_n;
            overflow     <= ovf_n;
        end
    end
endmodule

// File: tb/tb_rv32i_program_loader.sv
// Scoreboard bench for rv32i_program_loader: the driver queues expected memory writes,
// and a negedge monitor pops and compares every mem_we it sees.
module tb_rv32i_program_loader;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len_words = '0;
    logic          core_reset_n, busy, done, overflow;

    int checks = 0;
    int failures = 0;
    logic [AW+31:0] exp_q[$];

    rv32i_program_loader_if #(.ADDR_WIDTH(AW)) bus();

    rv32i_program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .len_words    (len_words),
        .bus          (bus),
        .core_reset_n (core_reset_n),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int a, input logic [31:0] d);
        exp_q.push_back({a[AW-1:0], d});
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        logic [AW+31:0] e;
        if (reset_n && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%h required=no_write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e[AW+31:32]));
                check("wr_data", bus.mem_wdata, e[31:0]);
            end
        end
        if (bus.in_ready)
            check("in_ready_outside_load", {30'd0, done, core_reset_n}, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW:0] len);
        start = 1'b1;
        len_words = len;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps, input int budget,
                             output logic accepted);
        int n;
        repeat (gaps) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < budget) begin
            accepted = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$], input logic gapped);
        logic acc;
        foreach (bytes[i]) begin
            send_byte(bytes[i], gapped ? int'($urandom_range(0, 2)) : 0, 20, acc);
            check("byte_accepted", {31'd0, acc}, 32'd1);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_core_reset_n"}, {31'd0, core_reset_n}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] img[$];
        logic acc;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Zero length from IDLE: done on the very next cycle, no writes.
        check("zero_done_before", {31'd0, done}, 32'd0);
        do_start(3'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_core_reset_n", {31'd0, core_reset_n}, 32'd1);
        check("zero_overflow", {31'd0, overflow}, 32'd0);
        check("zero_busy", {31'd0, busy}, 32'd0);
        tick();

        // Basic two-word load with in_valid held high.
        push_exp(0, 32'h00000013);
        push_exp(1, 32'h00100093);
        do_start(3'd2);
        check("basic_in_ready_t1", {31'd0, bus.in_ready}, 32'd1);
        check("basic_core_reset_low", {31'd0, core_reset_n}, 32'd0);
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_bytes(img, 1'b0);
        check("basic_flush_we", {31'd0, bus.mem_we}, 32'd1);
        check("basic_flush_core_reset", {31'd0, core_reset_n}, 32'd0);
        check("basic_flush_busy", {31'd0, busy}, 32'd1);
        tick();
        check("basic_core_reset_rise", {31'd0, core_reset_n}, 32'd1);
        check("basic_done", {31'd0, done}, 32'd1);
        check("basic_we_off", {31'd0, bus.mem_we}, 32'd0);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

        // Same image with random gaps between bytes.
        push_exp(0, 32'h00000013);
        push_exp(1, 32'h00100093);
        do_start(3'd2);
        send_bytes(img, 1'b1);
        wait_done(10);
        check("gaps_queue_empty", 32'(exp_q.size()), 32'd0);

        // Clamp: 6 words requested, memory holds 4.
        push_exp(0, 32'h13121110);
        push_exp(1, 32'h17161514);
        push_exp(2, 32'h1B1A1918);
        push_exp(3, 32'h1F1E1D1C);
        do_start(3'd6);
        img = {};
        for (int i = 0; i < 16; i++) img.push_back(8'(8'h10 + i));
        send_bytes(img, 1'b0);
        send_byte(8'h20, 0, 6, acc);
        check("clamp_byte17_rejected", {31'd0, acc}, 32'd0);
        check("clamp_overflow", {31'd0, overflow}, 32'd1);
        check("clamp_done", {31'd0, done}, 32'd1);
        check("clamp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reload from DONE; a start pulse mid-load is ignored.
        push_exp(0, 32'hDEADBEEF);
        do_start(3'd1);
        check("reload_core_reset_drop", {31'd0, core_reset_n}, 32'd0);
        check("reload_done_drop", {31'd0, done}, 32'd0);
        check("reload_overflow_cleared", {31'd0, overflow}, 32'd0);
        check("reload_in_ready", {31'd0, bus.in_ready}, 32'd1);
        img = '{8'hEF, 8'hBE};
        send_bytes(img, 1'b0);
        do_start(3'd3);
        check("reload_start_ignored_busy", {31'd0, busy}, 32'd1);
        img = '{8'hAD, 8'hDE};
        send_bytes(img, 1'b0);
        check("reload_flush_we", {31'd0, bus.mem_we}, 32'd1);
        tick();
        check("reload_core_reset_rise", {31'd0, core_reset_n}, 32'd1);
        check("reload_done", {31'd0, done}, 32'd1);
        repeat (4) tick();
        check("reload_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset after 6 bytes: partial second word must never appear.
        push_exp(0, 32'h04030201);
        do_start(3'd2);
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_bytes(img, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (3) tick();
        reset_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h07;
        repeat (6) tick();
        bus.in_valid = 1'b0;
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        check("midreset_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
